// File: rtl/tlv493_i2c_responder.sv
// tlv493_i2c_responder
//   I2C target emulating a TLV493D magnetic sensor at the protocol level.
//   It serves the 10-byte read map from a snapshot taken at address match and
//   accepts the configuration write (MOD1 = byte 1, MOD2 = byte 3).
// Ports
//   clock, reset          system clock (>=16x SCL), async active-high reset
//   scl_in, sda_in        raw bus lines (asynchronous)
//   sda_oe                1 = pull SDA low
//   sample_valid, mag_*,  sample load strobe and 12-bit samples
//   temp
//   cfg_mod1, cfg_mod2    last written MOD1 / MOD2
//   cfg_strobe            pulse on STOP after a write of >=4 bytes
//   frm                   2-bit frame counter
//   busy                  high from address match to STOP / repeated START
module tlv493_i2c_responder #(
    parameter logic [6:0] I2C_ADDR = 7'h5E,
    parameter logic [7:0] FACTORY7 = 8'h00,
    parameter logic [7:0] FACTORY8 = 8'h00,
    parameter logic [7:0] FACTORY9 = 8'h00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic        sample_valid,
    input  logic [11:0] mag_x,
    input  logic [11:0] mag_y,
    input  logic [11:0] mag_z,
    input  logic [11:0] temp,
    output logic [7:0]  cfg_mod1,
    output logic [7:0]  cfg_mod2,
    output logic        cfg_strobe,
    output logic [1:0]  frm,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, TX_BYTE, TX_MACK, RX_BYTE, RX_ACK, IGNORE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  scl_sync_q, sda_sync_q;
    logic        scl_prev_q, sda_prev_q;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        sda_oe_q, sda_oe_d;
    logic        busy_q, busy_d;
    logic        rw_q, rw_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [2:0]  rxcnt_q, rxcnt_d;
    logic [7:0]  mod1_q, mod1_d, mod2_q, mod2_d;
    logic        strobe_q, strobe_d;
    logic        snap_load;

    logic [11:0] smp_x_q, smp_y_q, smp_z_q, smp_t_q;
    logic [11:0] smp_x_d, smp_y_d, smp_z_d, smp_t_d;
    logic [1:0]  frm_q, frm_d;
    logic [11:0] snap_x_q, snap_y_q, snap_z_q, snap_t_q;
    logic [1:0]  snap_frm_q;
    logic [7:0]  tx_byte;

    logic scl_s, sda_s, scl_rise, scl_fall, start_c, stop_c;

    assign scl_s    = scl_sync_q[1];
    assign sda_s    = sda_sync_q[1];
    assign scl_rise = scl_s & ~scl_prev_q;
    assign scl_fall = ~scl_s & scl_prev_q;
    assign start_c  = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_c   = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    // Next sample values; the snapshot uses these so a strobe coinciding
    // with the address match is already visible in the read.
    assign smp_x_d = sample_valid ? mag_x : smp_x_q;
    assign smp_y_d = sample_valid ? mag_y : smp_y_q;
    assign smp_z_d = sample_valid ? mag_z : smp_z_q;
    assign smp_t_d = sample_valid ? temp  : smp_t_q;
    assign frm_d   = sample_valid ? frm_q + 2'd1 : frm_q;

    always_comb begin
        tx_byte = 8'h00;
        case (ptr_q)
            4'd0: tx_byte = snap_x_q[11:4];
            4'd1: tx_byte = snap_y_q[11:4];
            4'd2: tx_byte = snap_z_q[11:4];
            4'd3: tx_byte = {snap_t_q[11:8], snap_frm_q, 2'b00};
            4'd4: tx_byte = {snap_x_q[3:0], snap_y_q[3:0]};
            4'd5: tx_byte = {4'b0001, snap_z_q[3:0]};
            4'd6: tx_byte = snap_t_q[7:0];
            4'd7: tx_byte = FACTORY7;
            4'd8: tx_byte = FACTORY8;
            4'd9: tx_byte = FACTORY9;
            default: tx_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        rw_d      = rw_q;
        ptr_d     = ptr_q;
        rxcnt_d   = rxcnt_q;
        mod1_d    = mod1_q;
        mod2_d    = mod2_q;
        strobe_d  = 1'b0;
        snap_load = 1'b0;
        if (start_c) begin
            state_d  = ADDR;
            bitcnt_d = 3'd0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (stop_c) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            strobe_d = (rxcnt_q >= 3'd4);
            rxcnt_d  = 3'd0;
        end else begin
            case (state_q)
                ADDR: if (scl_rise) begin
                    shift_d  = {shift_q[6:0], sda_s};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        // First seven bits already sit in shift_q[6:0].
                        if (shift_q[6:0] == I2C_ADDR) begin
                            state_d   = ADDR_ACK;
                            busy_d    = 1'b1;
                            rw_d      = sda_s;
                            ptr_d     = 4'd0;
                            rxcnt_d   = 3'd0;
                            snap_load = 1'b1;
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) sda_oe_d = 1'b1;
                    if (scl_rise) begin
                        state_d  = rw_q ? TX_BYTE : RX_BYTE;
                        bitcnt_d = 3'd0;
                    end
                end
                TX_BYTE: begin
                    // 7-bitcnt == ~bitcnt for a 3-bit count: MSB first.
                    if (scl_fall) sda_oe_d = ~tx_byte[~bitcnt_q];
                    if (scl_rise) begin
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) state_d = TX_MACK;
                    end
                end
                TX_MACK: begin
                    if (scl_fall) sda_oe_d = 1'b0;
                    if (scl_rise) begin
                        if (sda_s) begin
                            state_d = IGNORE;
                        end else begin
                            state_d  = TX_BYTE;
                            bitcnt_d = 3'd0;
                            ptr_d    = (ptr_q == 4'd9) ? 4'd0 : ptr_q + 4'd1;
                        end
                    end
                end
                RX_BYTE: begin
                    if (scl_fall) sda_oe_d = 1'b0;
                    if (scl_rise) begin
                        shift_d  = {shift_q[6:0], sda_s};
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) state_d = RX_ACK;
                    end
                end
                RX_ACK: begin
                    if (scl_fall) sda_oe_d = 1'b1;
                    if (scl_rise) begin
                        state_d  = RX_BYTE;
                        bitcnt_d = 3'd0;
                        if (rxcnt_q == 3'd1) mod1_d = shift_q;
                        if (rxcnt_q == 3'd3) mod2_d = shift_q;
                        // Saturate: only ">=4 bytes" matters beyond index 3.
                        if (rxcnt_q < 3'd4) rxcnt_d = rxcnt_q + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= IDLE;
            bitcnt_q   <= 3'd0;
            shift_q    <= 8'h00;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            rw_q       <= 1'b0;
            ptr_q      <= 4'd0;
            rxcnt_q    <= 3'd0;
            mod1_q     <= 8'h00;
            mod2_q     <= 8'h00;
            strobe_q   <= 1'b0;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_in};
            sda_sync_q <= {sda_sync_q[0], sda_in};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            rw_q       <= rw_d;
            ptr_q      <= ptr_d;
            rxcnt_q    <= rxcnt_d;
            mod1_q     <= mod1_d;
            mod2_q     <= mod2_d;
            strobe_q   <= strobe_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            smp_x_q    <= '0;
            smp_y_q    <= '0;
            smp_z_q    <= '0;
            smp_t_q    <= '0;
            frm_q      <= '0;
            snap_x_q   <= '0;
            snap_y_q   <= '0;
            snap_z_q   <= '0;
            snap_t_q   <= '0;
            snap_frm_q <= '0;
        end else begin
            smp_x_q <= smp_x_d;
            smp_y_q <= smp_y_d;
            smp_z_q <= smp_z_d;
            smp_t_q <= smp_t_d;
            frm_q   <= frm_d;
            if (snap_load) begin
                snap_x_q   <= smp_x_d;
                snap_y_q   <= smp_y_d;
                snap_z_q   <= smp_z_d;
                snap_t_q   <= smp_t_d;
                snap_frm_q <= frm_d;
            end
        end
    end

    assign sda_oe     = sda_oe_q;
    assign cfg_mod1   = mod1_q;
    assign cfg_mod2   = mod2_q;
    assign cfg_strobe = strobe_q;
    assign frm        = frm_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_tlv493_i2c_responder.sv
// Directed bench for tlv493_i2c_responder: a bit-banged I2C master with a
// queue of expected read bytes, plus bus-level monitors.
module tb_tlv493_i2c_responder;
    localparam int T = 8;  // quarter SCL phase, in clock cycles
    localparam logic [7:0] F7 = 8'hA5, F8 = 8'h5A, F9 = 8'h18;

    logic        clock = 1'b0, reset = 1'b1;
    logic        scl_m = 1'b1, sda_m = 1'b1, sample_valid = 1'b0;
    logic [11:0] mag_x = '0, mag_y = '0, mag_z = '0, temp = '0;
    logic        sda_oe, cfg_strobe, busy;
    logic [7:0]  cfg_mod1, cfg_mod2;
    logic [1:0]  frm;
    wire         sda_line = sda_m & ~sda_oe;

    int checks = 0, errors = 0, strobes = 0;
    logic oe_seen = 1'b0, busy_seen = 1'b0, oe_prev = 1'b0;
    logic [7:0] exp_q[$];

    always #5 clock = ~clock;

    tlv493_i2c_responder #(.I2C_ADDR(7'h5E), .FACTORY7(F7), .FACTORY8(F8), .FACTORY9(F9)) dut (
        .clock(clock), .reset(reset), .scl_in(scl_m), .sda_in(sda_line), .sda_oe(sda_oe),
        .sample_valid(sample_valid), .mag_x(mag_x), .mag_y(mag_y), .mag_z(mag_z), .temp(temp),
        .cfg_mod1(cfg_mod1), .cfg_mod2(cfg_mod2), .cfg_strobe(cfg_strobe), .frm(frm), .busy(busy)
    );

    always @(posedge clock) begin
        if (cfg_strobe) strobes++;
        if (sda_oe) oe_seen = 1'b1;
        if (busy) busy_seen = 1'b1;
        assert (!(sda_oe && !oe_prev && scl_m)) else begin
            errors++;
            $error("FAIL sda_oe_rise_scl_high: sda_oe rose while SCL high at %0t", $time);
        end
        oe_prev = sda_oe;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wt(input int n);
        repeat (n) @(negedge clock);
    endtask

    function automatic logic [7:0] mb(input int i, input logic [11:0] x, y, z, t, input logic [1:0] f);
        case (i % 10)
            0: return x[11:4];
            1: return y[11:4];
            2: return z[11:4];
            3: return {t[11:8], f, 2'b00};
            4: return {x[3:0], y[3:0]};
            5: return {4'b0001, z[3:0]};
            6: return t[7:0];
            7: return F7;
            8: return F8;
            default: return F9;
        endcase
    endfunction

    task automatic push_map(input int first, input int n, input logic [11:0] x, y, z, t,
                            input logic [1:0] f);
        for (int i = first; i < first + n; i++) exp_q.push_back(mb(i, x, y, z, t, f));
    endtask

    task automatic load(input logic [11:0] x, y, z, t);
        @(negedge clock);
        mag_x = x; mag_y = y; mag_z = z; temp = t; sample_valid = 1'b1;
        @(negedge clock);
        sample_valid = 1'b0;
    endtask

    task automatic i2c_start;
        sda_m = 1'b1; wt(T); scl_m = 1'b1; wt(2 * T);
        sda_m = 1'b0; wt(2 * T); scl_m = 1'b0; wt(T);
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0; wt(T); scl_m = 1'b1; wt(2 * T);
        sda_m = 1'b1; wt(4 * T);
    endtask

    task automatic wr_bit(input logic b);
        sda_m = b; wt(T); scl_m = 1'b1; wt(2 * T); scl_m = 1'b0; wt(T);
    endtask

    task automatic rd_bit(output logic b);
        sda_m = 1'b1; wt(T); scl_m = 1'b1; wt(T); b = sda_line; wt(T); scl_m = 1'b0; wt(T);
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) wr_bit(d[i]);
        rd_bit(ack);
    endtask

    task automatic rd_byte(input logic nack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin rd_bit(b); d[i] = b; end
        wr_bit(nack);
    endtask

    // Reads n bytes, NACKing the last when last_nack is set, and compares each
    // one against the head of the expectation queue.
    task automatic rd_bytes(input int n, input logic last_nack, input string tag);
        logic [7:0] d, e;
        for (int i = 0; i < n; i++) begin
            rd_byte(last_nack && (i == n - 1), d);
            e = exp_q.pop_front();
            chk($sformatf("%s_b%0d", tag, i), {24'h0, d}, {24'h0, e});
        end
    endtask

    initial begin
        logic ack, acc;
        logic [7:0] d;
        int s0;

        wt(4); reset = 1'b0; wt(4);
        chk("rst_sda_oe", {31'h0, sda_oe}, 32'h0);
        chk("rst_mod1", {24'h0, cfg_mod1}, 32'h0);
        chk("rst_mod2", {24'h0, cfg_mod2}, 32'h0);
        chk("rst_strobe", {31'h0, cfg_strobe}, 32'h0);
        chk("rst_frm", {30'h0, frm}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);

        // Basic 7-byte read with literal expectations.
        load(12'hABC, 12'h123, 12'h456, 12'h789);
        chk("frm_after_load", {30'h0, frm}, 32'd1);
        exp_q.push_back(8'hAB); exp_q.push_back(8'h12); exp_q.push_back(8'h45);
        exp_q.push_back(8'h74); exp_q.push_back(8'hC3); exp_q.push_back(8'h16);
        exp_q.push_back(8'h89);
        i2c_start; wr_byte(8'hBD, ack);
        chk("rd7_addr_ack", {31'h0, ack}, 32'h0);
        chk("rd7_busy", {31'h0, busy}, 32'h1);
        rd_bytes(7, 1'b1, "rd7");
        i2c_stop;
        chk("rd7_busy_after_stop", {31'h0, busy}, 32'h0);

        // Wrong address, write and read direction.
        oe_seen = 1'b0; busy_seen = 1'b0;
        i2c_start; wr_byte(8'hBE, ack); wr_byte(8'h00, acc); i2c_stop;
        chk("5F_w_nack", {31'h0, ack}, 32'h1);
        i2c_start; wr_byte(8'hBF, ack); i2c_stop;
        chk("5F_r_nack", {31'h0, ack}, 32'h1);
        chk("5F_no_oe", {31'h0, oe_seen}, 32'h0);
        chk("5F_no_busy", {31'h0, busy_seen}, 32'h0);

        // 4-byte configuration write.
        s0 = strobes; acc = 1'b0;
        i2c_start; wr_byte(8'hBC, ack); acc |= ack;
        wr_byte(8'h00, ack); acc |= ack; wr_byte(8'h05, ack); acc |= ack;
        wr_byte(8'h00, ack); acc |= ack; wr_byte(8'h40, ack); acc |= ack;
        i2c_stop;
        chk("wr4_acks", {31'h0, acc}, 32'h0);
        chk("wr4_mod1", {24'h0, cfg_mod1}, 32'h05);
        chk("wr4_mod2", {24'h0, cfg_mod2}, 32'h40);
        chk("wr4_strobes", strobes - s0, 32'd1);

        // 3-byte write: MOD1 still updates, no strobe.
        s0 = strobes; acc = 1'b0;
        i2c_start; wr_byte(8'hBC, ack); acc |= ack;
        wr_byte(8'h00, ack); acc |= ack; wr_byte(8'h07, ack); acc |= ack;
        wr_byte(8'h00, ack); acc |= ack;
        i2c_stop;
        chk("wr3_acks", {31'h0, acc}, 32'h0);
        chk("wr3_mod1", {24'h0, cfg_mod1}, 32'h07);
        chk("wr3_mod2_kept", {24'h0, cfg_mod2}, 32'h40);
        chk("wr3_no_strobe", strobes - s0, 32'd0);

        // 12-byte read: pointer wraps after byte 9.
        push_map(0, 12, 12'hABC, 12'h123, 12'h456, 12'h789, 2'd1);
        i2c_start; wr_byte(8'hBD, ack);
        chk("rd12_addr_ack", {31'h0, ack}, 32'h0);
        rd_bytes(12, 1'b1, "rd12");
        i2c_stop;

        // NACK after byte 2: target releases, stays off the bus.
        push_map(0, 2, 12'hABC, 12'h123, 12'h456, 12'h789, 2'd1);
        i2c_start; wr_byte(8'hBD, ack);
        chk("nack_addr_ack", {31'h0, ack}, 32'h0);
        rd_bytes(2, 1'b1, "nack");
        oe_seen = 1'b0;
        rd_byte(1'b1, d);
        chk("nack_bus_idle", {24'h0, d}, 32'hFF);
        chk("nack_no_oe", {31'h0, oe_seen}, 32'h0);
        i2c_stop;
        push_map(0, 2, 12'hABC, 12'h123, 12'h456, 12'h789, 2'd1);
        i2c_start; wr_byte(8'hBD, ack);
        chk("after_nack_ack", {31'h0, ack}, 32'h0);
        rd_bytes(2, 1'b1, "after_nack");
        i2c_stop;

        // Sample strobe mid-read: snapshot holds, next read shows new data.
        push_map(0, 7, 12'hABC, 12'h123, 12'h456, 12'h789, 2'd1);
        i2c_start; wr_byte(8'hBD, ack);
        chk("mid_addr_ack", {31'h0, ack}, 32'h0);
        rd_bytes(2, 1'b0, "mid_old");
        load(12'h321, 12'hFED, 12'h0F0, 12'h5A5);
        rd_bytes(5, 1'b1, "mid_old_tail");
        i2c_stop;
        push_map(0, 7, 12'h321, 12'hFED, 12'h0F0, 12'h5A5, 2'd2);
        i2c_start; wr_byte(8'hBD, ack);
        chk("new_addr_ack", {31'h0, ack}, 32'h0);
        rd_bytes(7, 1'b1, "new");
        i2c_stop;

        // Four strobes: frame counter wraps to the same value.
        repeat (4) load(12'h321, 12'hFED, 12'h0F0, 12'h5A5);
        chk("frm_wrap4", {30'h0, frm}, 32'd2);

        // Reset while the target drives a 0 data bit (byte 0 = 0x32, MSB 0).
        i2c_start; wr_byte(8'hBD, ack);
        chk("rst_tx_addr_ack", {31'h0, ack}, 32'h0);
        chk("rst_tx_driving", {31'h0, sda_oe}, 32'h1);
        reset = 1'b1; #1;
        chk("rst_tx_release", {31'h0, sda_oe}, 32'h0);
        wt(2); reset = 1'b0; wt(2);
        chk("rst_tx_frm", {30'h0, frm}, 32'd0);
        push_map(0, 7, 12'h000, 12'h000, 12'h000, 12'h000, 2'd0);
        i2c_start; wr_byte(8'hBD, ack);
        chk("post_rst_ack", {31'h0, ack}, 32'h0);
        rd_bytes(7, 1'b1, "post_rst");
        i2c_stop;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
